button_step_gen: RTL and testbench



---
 rtl/button_step_gen.sv | 94 +++++++++
 tb/tb_button_step_gen.sv | 118 +++++++++++
 2 files changed

// File: rtl/button_step_gen.sv
// button_step_gen: debounced front-panel buttons to one-cycle step/preset pulses with hold-to-repeat.
module button_step_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_dn,
  input  logic btn_preset,
  output logic step_up,
  output logic step_dn,
  output logic preset,
  output logic held_up,
  output logic held_dn
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;
  state_t state;
  logic [2:0] raw, s1, s2, lvl, lvl_d, rise;
  logic [DW-1:0] cnt [3];
  logic [RW-1:0] rcnt;
  logic dir, dir_held, opp_held;
  assign raw = {btn_preset, btn_dn, btn_up};
  assign rise = lvl & ~lvl_d;
  assign held_up = lvl[0];
  assign held_dn = lvl[1];
  assign dir_held = dir ? lvl[1] : lvl[0];
  assign opp_held = dir ? lvl[0] : lvl[1];
  // bit 0 = up, 1 = dn, 2 = preset; the level flips once the mismatch has lasted DEBOUNCE_CYCLES
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      lvl <= '0;
      lvl_d <= '0;
      for (int b = 0; b < 3; b++) cnt[b] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      lvl_d <= lvl;
      for (int b = 0; b < 3; b++)
        if (s2[b] == lvl[b]) cnt[b] <= '0;
        else if (cnt[b] == DW'(DEBOUNCE_CYCLES)) begin
          lvl[b] <= ~lvl[b];
          cnt[b] <= '0;
        end else cnt[b] <= cnt[b] + 1'b1;
    end
  // dir: 0 = up, 1 = dn; preset overrides everything and parks the FSM in LOCK
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rcnt <= '0;
      dir <= 1'b0;
      step_up <= 1'b0;
      step_dn <= 1'b0;
      preset <= 1'b0;
    end else begin
      step_up <= 1'b0;
      step_dn <= 1'b0;
      preset <= 1'b0;
      if (rise[2]) begin
        preset <= 1'b1;
        state <= LOCK;
      end else
        case (state)
          IDLE:
            if (rise[0] | rise[1]) begin
              if (lvl[0] & lvl[1]) state <= LOCK;
              else begin
                step_up <= rise[0];
                step_dn <= rise[1];
                dir <= rise[1];
                rcnt <= '0;
                state <= DELAY;
              end
            end
          DELAY, REPEAT:
            if (!dir_held) state <= IDLE;
            else if (opp_held) state <= LOCK;
            else if (rcnt == (state == DELAY ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1))) begin
              step_up <= ~dir;
              step_dn <= dir;
              rcnt <= '0;
              state <= REPEAT;
            end else rcnt <= rcnt + 1'b1;
          LOCK: state <= lvl == 3'b000 ? IDLE : LOCK;
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_button_step_gen.sv
// tb_button_step_gen: directed checks of debounce latency, repeat cadence, lockout, preset and reset.
module tb_button_step_gen;
  logic clk = 0, rst = 1, btn_up = 0, btn_dn = 0, btn_preset = 0;
  logic step_up, step_dn, preset, held_up, held_dn;
  int total = 0, bad = 0, n_up = 0, n_dn = 0, n_pr = 0;
  logic multi = 0;
  button_step_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .btn_preset(btn_preset),
    .step_up(step_up), .step_dn(step_dn), .preset(preset), .held_up(held_up), .held_dn(held_dn)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (step_up) n_up++;
    if (step_dn) n_dn++;
    if (preset) n_pr++;
    if (int'(step_up) + int'(step_dn) + int'(preset) > 1) multi = 1;
  end
  task automatic wait_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  initial begin
    int u0, d0, p0;
    logic seen;
    wait_n(3);
    chk("reset_outputs", {step_up, step_dn, preset, held_up, held_dn}, 0);
    rst = 0;
    wait_n(2);
    // single press: held at sample+6, pulse at sample+7
    btn_up = 1;
    wait_n(6); chk("t1_held_early", held_up, 0);
    wait_n(1); chk("t1_held", held_up, 1); chk("t1_no_early_pulse", step_up, 0);
    wait_n(1); chk("t1_pulse", step_up, 1);
    wait_n(1); chk("t1_width", step_up, 0);
    wait_n(3); btn_up = 0;
    wait_n(6); chk("t1_release_early", held_up, 1);
    wait_n(1); chk("t1_released", held_up, 0);
    wait_n(15); chk("t1_count", n_up, 1);
    // bounce shorter than the debounce window
    u0 = n_up; seen = 0;
    for (int i = 0; i < 20; i++) begin
      btn_up = ((i / 2) % 2 == 0);
      wait_n(1);
      if (held_up) seen = 1;
    end
    chk("t2_bounce_held", seen, 0);
    btn_up = 1;
    wait_n(12); chk("t2_held", held_up, 1); chk("t2_count", n_up - u0, 1);
    btn_up = 0;
    wait_n(15);
    // hold down: pulses at 0,20,25,...; raw release after 59, debounced release ends it after 65
    btn_dn = 1;
    wait_n(8);
    for (int r = 0; r < 80; r++) begin
      chk("t3_step_dn", step_dn, (r == 0) || (r >= 20 && r <= 65 && r % 5 == 0));
      chk("t3_step_up", step_up, 0);
      if (r == 59) btn_dn = 0;
      wait_n(1);
    end
    chk("t3_held_dn", held_dn, 0);
    // opposite press during repeat locks out both directions
    btn_up = 1;
    wait_n(8); chk("t4_first", step_up, 1);
    wait_n(25); chk("t4_repeat", step_up, 1);
    btn_dn = 1;
    wait_n(10); chk("t4_held_dn", held_dn, 1);
    u0 = n_up; d0 = n_dn;
    wait_n(30);
    btn_up = 0;
    wait_n(12);
    chk("t4_lock_pulses", (n_up - u0) + (n_dn - d0), 0);
    btn_dn = 0;
    wait_n(10);
    d0 = n_dn; btn_dn = 1;
    wait_n(8); chk("t4_dn_after", step_dn, 1);
    btn_dn = 0;
    wait_n(15); chk("t4_dn_count", n_dn - d0, 1);
    // preset during repeat wins over the coinciding step
    btn_up = 1;
    wait_n(8); wait_n(27);
    p0 = n_pr; btn_preset = 1;
    wait_n(7); chk("t5_preset_early", preset, 0);
    wait_n(1); chk("t5_preset", preset, 1); chk("t5_no_step", step_up, 0);
    u0 = n_up;
    wait_n(20); chk("t5_up_stopped", n_up - u0, 0); chk("t5_preset_count", n_pr - p0, 1);
    btn_up = 0; btn_preset = 0;
    wait_n(12);
    u0 = n_up; btn_up = 1;
    wait_n(8); chk("t5_up_after", step_up, 1);
    btn_up = 0;
    wait_n(15); chk("t5_up_count", n_up - u0, 1);
    // reset mid-repeat with the button still held
    btn_up = 1;
    wait_n(8); wait_n(25); chk("t6_pre_reset", step_up, 1);
    rst = 1; #1;
    chk("t6_async_clear", {step_up, step_dn, preset, held_up, held_dn}, 0);
    wait_n(3); rst = 0;
    wait_n(6); chk("t6_held_early", held_up, 0);
    wait_n(1); chk("t6_held", held_up, 1); chk("t6_no_early", step_up, 0);
    wait_n(1); chk("t6_first", step_up, 1);
    wait_n(19); chk("t6_gap", step_up, 0);
    wait_n(1); chk("t6_delay", step_up, 1);
    wait_n(4); chk("t6_gap2", step_up, 0);
    wait_n(1); chk("t6_period", step_up, 1);
    btn_up = 0;
    wait_n(15);
    chk("one_hot_pulses", multi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
